// File: rtl/adder_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder tree.
//   DEF_IN_W / DEF_N_IN : default operand width and operand count
//   clog2()             : ceiling log2, used to size the tree result
//   level_n()           : number of live elements entering a given tree level
//   n_levels()          : number of registered levels for an operand count
package adder_tree_pkg;

    localparam int DEF_IN_W = 17;
    localparam int DEF_N_IN = 25;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Each level halves the element count, rounding up for the pass-through.
    function automatic int level_n(input int n_in, input int lvl);
        int n;
        n = n_in;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic int n_levels(input int n_in);
        return clog2(n_in);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: adds adjacent element pairs and
// passes an odd trailing element through unchanged.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : stage enable; register holds when low
//   i_data     : N packed elements of W bits
//   o_data     : (N+1)/2 packed registered results
module adder_tree_level #(
    parameter int N = 2,
    parameter int W = 8,
    localparam int M = (N + 1) / 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N*W-1:0] i_data,
    output logic [M*W-1:0] o_data
);

    logic [M*W-1:0] w_sum;
    logic [M*W-1:0] r_sum;

    // Width W is sized by the caller so that no pair sum can overflow;
    // plain modular addition is therefore exact in two's complement.
    for (genvar j = 0; j < N / 2; j++) begin : g_pair
        assign w_sum[j*W +: W] = i_data[2*j*W +: W] + i_data[(2*j+1)*W +: W];
    end

    if (N % 2 == 1) begin : g_odd
        assign w_sum[(M-1)*W +: W] = i_data[(N-1)*W +: W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  r_sum <= '0;
        else if (en) r_sum <= w_sum;
    end

    assign o_data = r_sum;

endmodule

// File: rtl/adder_tree_acc_pipe.sv
// Pipelined signed adder tree followed by a group accumulator.
// Each accepted beat sums N_IN operands through clog2(N_IN) registered
// levels; the accumulate stage folds beat sums into a group total and
// emits it on the beat flagged last. A single global enable stalls the
// whole pipeline while a result waits for the consumer.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input beat handshake
//   in_data             : N_IN packed IN_W-bit signed operands
//   in_first / in_last  : group delimiters
//   out_valid/out_ready : result handshake
//   out_sum             : ACC_W-bit signed group sum
//   out_sat             : overflow (saturate or wrap) seen in this group
module adder_tree_acc_pipe
    import adder_tree_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int IN_W  = DEF_IN_W,
    parameter int SUM_W = IN_W + clog2(N_IN),
    parameter int ACC_W = SUM_W + 8,
    parameter bit SAT   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 out_sat
);

    localparam int L = n_levels(N_IN);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                 w_en;
    logic [N_IN*SUM_W-1:0] w_ext;
    logic [SUM_W-1:0]     w_tree_sum;

    logic [L-1:0]         r_vld;
    logic [L-1:0]         r_first;
    logic [L-1:0]         r_last;

    logic [ACC_W-1:0]     r_acc;
    logic                 r_sat;
    logic [ACC_W-1:0]     r_out_sum;
    logic                 r_out_sat;
    logic                 r_out_valid;

    logic [ACC_W-1:0]     w_tree_acc;
    logic [ACC_W-1:0]     w_base;
    logic [ACC_W:0]       w_wide;
    logic                 w_ovf;
    logic [ACC_W-1:0]     w_res;
    logic                 w_sat_grp;

    // Only a pending, unaccepted result stalls the pipe.
    assign w_en     = !(r_out_valid && !out_ready);
    assign in_ready = w_en;

    for (genvar k = 0; k < N_IN; k++) begin : g_ext
        assign w_ext[k*SUM_W +: SUM_W] = SUM_W'($signed(in_data[k*IN_W +: IN_W]));
    end

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int NI = level_n(N_IN, l);
        localparam int NO = (NI + 1) / 2;
        logic [NI*SUM_W-1:0] w_in;
        logic [NO*SUM_W-1:0] w_out;

        if (l == 0) begin : g_src
            assign w_in = w_ext;
        end else begin : g_src
            assign w_in = g_lvl[l-1].w_out;
        end

        adder_tree_level #(.N(NI), .W(SUM_W)) u_level (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (w_en),
            .i_data (w_in),
            .o_data (w_out)
        );
    end

    assign w_tree_sum = g_lvl[L-1].w_out;

    // Beat qualifiers ride alongside the tree; index i matches level i output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
        end else if (w_en) begin
            r_vld[0]   <= in_valid;
            r_first[0] <= in_first;
            r_last[0]  <= in_last;
            for (int i = 1; i < L; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_first[i] <= r_first[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    // One extra bit catches signed overflow: the top two bits disagree.
    always_comb begin
        w_tree_acc = ACC_W'($signed(w_tree_sum));
        w_base     = r_first[L-1] ? '0 : r_acc;
        w_wide     = {w_base[ACC_W-1], w_base} + {w_tree_acc[ACC_W-1], w_tree_acc};
        w_ovf      = w_wide[ACC_W] ^ w_wide[ACC_W-1];
        w_res      = w_wide[ACC_W-1:0];
        if (SAT && w_ovf) w_res = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        w_sat_grp  = (r_first[L-1] ? 1'b0 : r_sat) | w_ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_vld[L-1] && r_last[L-1];
            if (r_vld[L-1]) begin
                if (r_last[L-1]) begin
                    // Group closes: publish and start the next from zero.
                    r_out_sum <= w_res;
                    r_out_sat <= w_sat_grp;
                    r_acc     <= '0;
                    r_sat     <= 1'b0;
                end else begin
                    r_acc     <= w_res;
                    r_sat     <= w_sat_grp;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_adder_tree_acc_pipe.sv
module tb_adder_tree_acc_pipe;

    localparam int N_IN  = 25;
    localparam int IN_W  = 17;
    localparam int ACC_A = 30;   // default: SUM_W(22) + 8
    localparam int ACC_B = 24;

    typedef struct {
        longint sum_a;
        bit     sat_a;
        longint sum_b;
        bit     sat_b;
        bit     chk_b;
        bit     chk_lat;
        int     drv_cyc;
    } exp_t;

    typedef struct {
        int     base;
        int     step;
        longint sum;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [N_IN*IN_W-1:0] in_data;
    logic                 in_first;
    logic                 in_last;
    logic                 out_ready;

    logic                 in_ready_a, out_valid_a, out_sat_a;
    logic [ACC_A-1:0]     out_sum_a;
    logic                 in_ready_b, out_valid_b, out_sat_b;
    logic [ACC_B-1:0]     out_sum_b;

    adder_tree_acc_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a), .out_sat(out_sat_a)
    );

    adder_tree_acc_pipe #(.ACC_W(ACC_B), .SAT(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b), .out_sat(out_sat_b)
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    exp_t   q[$];
    bit     stall_prev = 0;
    longint held_sum = 0;
    bit     win = 0;
    int     n_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N_IN*IN_W-1:0] mk(input int base, input int step);
        logic [N_IN*IN_W-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < N_IN; k++) begin
            v = base + k * step;
            r[k*IN_W +: IN_W] = v[IN_W-1:0];
        end
        return r;
    endfunction

    function automatic exp_t mkexp(input longint sa, input bit ta, input longint sb,
                                   input bit tb, input bit cb, input bit cl);
        exp_t e;
        e.sum_a = sa; e.sat_a = ta; e.sum_b = sb; e.sat_b = tb;
        e.chk_b = cb; e.chk_lat = cl; e.drv_cyc = 0;
        return e;
    endfunction

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", longint'(out_valid_a), 1);
                chk("hold_sum", longint'($signed(out_sum_a)), held_sum);
            end
            if (win) begin
                chk("stall_in_ready", longint'(in_ready_a), 0);
                if (!in_ready_a) n_low++;
            end
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got sum %0d, expected no result", $signed(out_sum_a));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum_a", longint'($signed(out_sum_a)), e.sum_a);
                    chk("sat_a", longint'(out_sat_a), longint'(e.sat_a));
                    if (e.chk_b) begin
                        chk("valid_b", longint'(out_valid_b), 1);
                        chk("sum_b", longint'($signed(out_sum_b)), e.sum_b);
                        chk("sat_b", longint'(out_sat_b), longint'(e.sat_b));
                    end
                    if (e.chk_lat) chk("latency", longint'(cyc - e.drv_cyc), 6);
                end
            end
            stall_prev = out_valid_a && !out_ready;
            held_sum   = $signed(out_sum_a);
        end
    end

    // Present a beat and hold it until accepted; optionally expect a result.
    task automatic send(input int base, input int step, input bit first, input bit last,
                        input bit push, input exp_t e);
        bit ok;
        int tries;
        int acc_cyc;
        exp_t ee;
        ok = 0; tries = 0; acc_cyc = 0;
        in_data  = mk(base, step);
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready_a;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            tries++;
            if (!ok && tries > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        if (push && ok) begin
            ee = e;
            ee.drv_cyc = acc_cyc;
            q.push_back(ee);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (10) begin @(posedge clk); #1; end
    endtask

    vec_t vecs[7];
    exp_t none;

    initial begin
        none = mkexp(0, 0, 0, 0, 0, 0);
        vecs[0] = '{1,      0,  25};
        vecs[1] = '{-65536, 0,  -1638400};
        vecs[2] = '{0,      1,  300};
        vecs[3] = '{65535,  0,  1638375};
        vecs[4] = '{-3,     2,  525};
        vecs[5] = '{100,   -8,  100};
        vecs[6] = '{-65536, 1,  -1638100};

        rst_n = 1'b0; in_valid = 0; in_first = 0; in_last = 0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_a", longint'(out_valid_a), 0);
        chk("rst_sum_a", longint'(out_sum_a), 0);
        chk("rst_sat_a", longint'(out_sat_a), 0);
        chk("rst_ready_a", longint'(in_ready_a), 1);
        chk("rst_valid_b", longint'(out_valid_b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // One-beat group of all +1, latency measured.
        send(1, 0, 1, 1, 1, mkexp(25, 0, 25, 0, 1, 1));
        idle(1);
        drain();

        // Table of one-beat groups, back-to-back.
        for (int i = 0; i < 7; i++)
            send(vecs[i].base, vecs[i].step, 1, 1, 1,
                 mkexp(vecs[i].sum, 0, vecs[i].sum, 0, 1, 0));
        drain();

        // Three-beat group with a bubble, then a last-only beat starting from 0.
        send(1, 0, 1, 0, 0, none);
        send(2, 0, 0, 0, 0, none);
        idle(2);
        send(3, 0, 0, 1, 1, mkexp(150, 0, 150, 0, 1, 0));
        send(4, 0, 0, 1, 1, mkexp(100, 0, 100, 0, 1, 0));
        drain();

        // Six-beat group of all 65535: B saturates, A does not; sticky clears next group.
        for (int b = 0; b < 6; b++)
            send(65535, 0, b == 0, b == 5, b == 5, mkexp(9830250, 0, 8388607, 1, 1, 0));
        send(1, 0, 1, 1, 1, mkexp(25, 0, 25, 0, 1, 0));
        drain();

        // Continuous one-beat groups with the consumer stalled for 4 cycles.
        n_low = 0;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(i, 0, 1, 1, 1, mkexp(25 * i, 0, 25 * i, 0, 1, 0));
                in_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                do begin @(negedge clk); t++; end while (!out_valid_a && t < 100);
                if (!out_valid_a) chk("stall_wait_timeout", 0, 1);
                @(posedge clk); #1;
                out_ready = 1'b0; win = 1;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1; win = 0;
            end
        join
        drain();
        chk("stall_low_cycles", n_low, 4);

        // Reset with an in-flight one-beat group and a partial group: all discarded.
        send(7, 0, 1, 1, 0, none);
        send(1, 0, 1, 0, 0, none);
        send(2, 0, 0, 0, 0, none);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", longint'(in_ready_a), 1);
        chk("post_rst_valid", longint'(out_valid_a), 0);
        @(posedge clk); #1;
        send(2, 0, 1, 1, 1, mkexp(50, 0, 50, 0, 1, 0));
        send(1, 0, 0, 1, 1, mkexp(25, 0, 25, 0, 1, 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
